// File: rtl/vga_pkg.sv
// Shared timing constants, pixel types and helpers for the VGA timing pipeline.
// The defaults describe standard 640x480@60 with negative syncs and a two-cycle source.
package vga_pkg;

   localparam int DEF_COLOR_W  = 8;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_PIPE     = 2;

   localparam int COLOR_W = DEF_COLOR_W;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_t;

   // Total line or frame length in pixel clocks or lines.
   function automatic int vgaTotal(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled WIDTH x DEPTH shift register with asynchronous reset to RESET_VAL.
// Every stage is exposed so the caller can tap an intermediate delay.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        pclk,
   input  logic                        reset,
   input  logic                        en,
   input  logic [WIDTH-1:0]            i_data,
   output logic [DEPTH-1:0][WIDTH-1:0] o_stages
);

   logic [DEPTH-1:0][WIDTH-1:0] r_stages;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_stages <= {DEPTH{RESET_VAL}};
      end else if (en) begin
         r_stages[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_stages[i] <= r_stages[i-1];
         end
      end
   end

   assign o_stages = r_stages;

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with a fetch look-ahead of PIPE cycles, so the
// colour from a latent pixel source leaves the block aligned with its sync and strobes.
module vga_timing_pipe
   import vga_pkg::*;
#(
   parameter int COLOR_W   = DEF_COLOR_W,
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int PIPE      = DEF_PIPE
) (
   input  logic                 pclk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [3*COLOR_W-1:0] vga_data,
   output logic                 req,
   output logic [9:0]           h_addr,
   output logic [9:0]           v_addr,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 valid,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 line_start,
   output logic                 frame_start
);

   localparam int H_TOTAL  = vgaTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL  = vgaTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int D        = PIPE + 1;
   localparam int CTRL_W   = 5;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam logic [9:0] X_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_MAX = 10'(V_TOTAL - 1);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE < 0 || PIPE > 7) begin : g_badParams
         $error("vga_timing_pipe: totals must be <= 1024 and PIPE within 0..7");
      end
   endgenerate

   logic [9:0]                   r_x;
   logic [9:0]                   r_y;
   logic [3*COLOR_W-1:0]         r_rgb;
   logic                         w_req;
   logic                         w_hsRaw;
   logic                         w_vsRaw;
   logic                         w_colorReq;
   logic [CTRL_W-1:0]            w_ctrlIn;
   logic [CTRL_W-1:0]            w_ctrlOut;
   logic [D-1:0][CTRL_W-1:0]     w_stages;

   // Raster position: x advances every enabled cycle, y advances on each x wrap.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (en) begin
         if (r_x == X_MAX) begin
            r_x <= '0;
            r_y <= (r_y == Y_MAX) ? '0 : r_y + 10'd1;
         end else begin
            r_x <= r_x + 10'd1;
         end
      end
   end

   assign w_req   = (int'(r_x) < H_ACTIVE) && (int'(r_y) < V_ACTIVE);
   assign w_hsRaw = (int'(r_x) >= HS_START) && (int'(r_x) < HS_END);
   assign w_vsRaw = (int'(r_y) >= VS_START) && (int'(r_y) < VS_END);

   assign req    = w_req;
   assign h_addr = w_req ? r_x : '0;
   assign v_addr = w_req ? r_y : '0;

   assign w_ctrlIn = {w_req && (r_x == '0) && (r_y == '0),
                      w_req && (r_x == '0),
                      w_vsRaw, w_hsRaw, w_req};

   vga_delay_line #(
      .WIDTH     (CTRL_W),
      .DEPTH     (D),
      .RESET_VAL (CTRL_W'(0))
   ) u_delay (
      .pclk     (pclk),
      .reset    (reset),
      .en       (en),
      .i_data   (w_ctrlIn),
      .o_stages (w_stages)
   );

   assign w_ctrlOut = w_stages[D-1];

   // The colour register needs the request state one stage before the outputs,
   // which is the undelayed request itself when the source has no latency.
   generate
      if (PIPE == 0) begin : g_tapDirect
         assign w_colorReq = w_req;
      end else begin : g_tapLine
         assign w_colorReq = w_stages[PIPE-1][0];
      end
   endgenerate

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_rgb <= '0;
      end else if (en) begin
         r_rgb <= w_colorReq ? vga_data : '0;
      end
   end

   assign valid       = w_ctrlOut[0];
   assign hsync       = w_ctrlOut[1] ? HSYNC_POL : !HSYNC_POL;
   assign vsync       = w_ctrlOut[2] ? VSYNC_POL : !VSYNC_POL;
   assign line_start  = w_ctrlOut[3];
   assign frame_start = w_ctrlOut[4];

   assign vga_r = r_rgb[3*COLOR_W-1:2*COLOR_W];
   assign vga_g = r_rgb[2*COLOR_W-1:COLOR_W];
   assign vga_b = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Randomised bench for vga_timing_pipe: a full-width 640-pixel instance and a tiny
// active-high PIPE=0 instance, both compared every cycle against a raster-arithmetic model.
module tb_vga_timing_pipe;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int pipe;
      bit hpol; bit vpol;
   } cfg_t;

   typedef struct packed {
      logic        req;
      logic [9:0]  hAddr;
      logic [9:0]  vAddr;
      logic        hs;
      logic        vs;
      logic        valid;
      logic [23:0] rgb;
      logic        ls;
      logic        fs;
   } obs_t;

   // Vertical timing of the large instance is shortened so whole frames fit the cycle budget.
   localparam cfg_t CFG_A = '{ha:640, hfp:16, hs:96, hbp:48, va:6, vfp:2, vs:2, vbp:3,
                              pipe:2, hpol:1'b0, vpol:1'b0};
   localparam cfg_t CFG_B = '{ha:4, hfp:1, hs:1, hbp:1, va:3, vfp:1, vs:1, vbp:1,
                              pipe:0, hpol:1'b1, vpol:1'b1};

   logic        pclk;
   logic        reset;
   logic        en;
   logic [23:0] dataA, dataB;
   logic        reqA, hsA, vsA, validA, lsA, fsA;
   logic        reqB, hsB, vsB, validB, lsB, fsB;
   logic [9:0]  hAddrA, vAddrA, hAddrB, vAddrB;
   logic [7:0]  rA, gA, bA, rB, gB, bB;
   obs_t        obsA, obsB;

   int n;
   int salt;
   int checkCount;
   int failCount;
   bit measureOn;
   int vCnt, hsLow, hsFirst, blankValid, lsPrev, lsPeriod, fsPrev, fsPeriod;

   vga_timing_pipe #(
      .COLOR_W(8), .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hfp), .H_SYNC(CFG_A.hs), .H_BP(CFG_A.hbp),
      .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vfp), .V_SYNC(CFG_A.vs), .V_BP(CFG_A.vbp),
      .HSYNC_POL(CFG_A.hpol), .VSYNC_POL(CFG_A.vpol), .PIPE(CFG_A.pipe)
   ) dutA (
      .pclk(pclk), .reset(reset), .en(en), .vga_data(dataA),
      .req(reqA), .h_addr(hAddrA), .v_addr(vAddrA), .hsync(hsA), .vsync(vsA),
      .valid(validA), .vga_r(rA), .vga_g(gA), .vga_b(bA),
      .line_start(lsA), .frame_start(fsA)
   );

   vga_timing_pipe #(
      .COLOR_W(8), .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hfp), .H_SYNC(CFG_B.hs), .H_BP(CFG_B.hbp),
      .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vfp), .V_SYNC(CFG_B.vs), .V_BP(CFG_B.vbp),
      .HSYNC_POL(CFG_B.hpol), .VSYNC_POL(CFG_B.vpol), .PIPE(CFG_B.pipe)
   ) dutB (
      .pclk(pclk), .reset(reset), .en(en), .vga_data(dataB),
      .req(reqB), .h_addr(hAddrB), .v_addr(vAddrB), .hsync(hsB), .vsync(vsB),
      .valid(validB), .vga_r(rB), .vga_g(gB), .vga_b(bB),
      .line_start(lsB), .frame_start(fsB)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always_comb begin
      obsA = '0;
      obsA = '{req:reqA, hAddr:hAddrA, vAddr:vAddrA, hs:hsA, vs:vsA, valid:validA,
               rgb:{rA, gA, bA}, ls:lsA, fs:fsA};
      obsB = '0;
      obsB = '{req:reqB, hAddr:hAddrB, vAddr:vAddrB, hs:hsB, vs:vsB, valid:validB,
               rgb:{rB, gB, bB}, ls:lsB, fs:fsB};
   end

   function automatic logic [23:0] pixVal(input int x, input int y);
      int v;
      v = x * 2654435 + y * 40503 + salt;
      return v[23:0];
   endfunction

   // Expected block state after n enabled clocks since reset release: the request side
   // shows raster position n, the output side shows position n-(PIPE+1).
   function automatic obs_t expectedObs(input cfg_t c, input int cnt);
      obs_t e;
      int ht, vt, x, y, m;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      e = '0;
      x = cnt % ht;
      y = (cnt / ht) % vt;
      e.req = (x < c.ha) && (y < c.va);
      if (e.req) begin
         e.hAddr = 10'(x);
         e.vAddr = 10'(y);
      end
      e.hs = !c.hpol;
      e.vs = !c.vpol;
      m = cnt - (c.pipe + 1);
      if (m >= 0) begin
         x = m % ht;
         y = (m / ht) % vt;
         if (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) e.hs = c.hpol;
         if (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) e.vs = c.vpol;
         if (x < c.ha && y < c.va) begin
            e.valid = 1'b1;
            e.rgb   = pixVal(x, y);
            e.ls    = (x == 0);
            e.fs    = (x == 0) && (y == 0);
         end
      end
      return e;
   endfunction

   // Pixel source honouring the contract: data for request k appears PIPE enabled cycles later.
   function automatic logic [23:0] srcData(input cfg_t c, input int cnt);
      int ht, vt, x, y, m;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      m  = cnt - c.pipe;
      if (m >= 0) begin
         x = m % ht;
         y = (m / ht) % vt;
         if (x < c.ha && y < c.va) return pixVal(x, y);
      end
      return 24'($urandom);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s n=%0d observed=%0h expected=%0h", tag, n, observed, expected);
      end
   endtask

   task automatic checkDut(input string name, input obs_t o, input obs_t e);
      checkOutput({name, ".req"},         64'(o.req),   64'(e.req));
      checkOutput({name, ".h_addr"},      64'(o.hAddr), 64'(e.hAddr));
      checkOutput({name, ".v_addr"},      64'(o.vAddr), 64'(e.vAddr));
      checkOutput({name, ".hsync"},       64'(o.hs),    64'(e.hs));
      checkOutput({name, ".vsync"},       64'(o.vs),    64'(e.vs));
      checkOutput({name, ".valid"},       64'(o.valid), 64'(e.valid));
      checkOutput({name, ".rgb"},         64'(o.rgb),   64'(e.rgb));
      checkOutput({name, ".line_start"},  64'(o.ls),    64'(e.ls));
      checkOutput({name, ".frame_start"}, 64'(o.fs),    64'(e.fs));
   endtask

   task automatic checkAll();
      checkDut("A", obsA, expectedObs(CFG_A, n));
      checkDut("B", obsB, expectedObs(CFG_B, n));
   endtask

   task automatic measureA();
      int m, ht, vt;
      ht = CFG_A.ha + CFG_A.hfp + CFG_A.hs + CFG_A.hbp;
      vt = CFG_A.va + CFG_A.vfp + CFG_A.vs + CFG_A.vbp;
      m  = n - (CFG_A.pipe + 1);
      if (m >= 0 && m < ht) begin
         if (validA) vCnt++;
         if (!hsA) begin
            if (hsFirst < 0) hsFirst = m;
            hsLow++;
         end
      end
      if (m >= CFG_A.va * ht && m < vt * ht && validA) blankValid++;
      if (lsA) begin
         if (lsPrev >= 0 && lsPeriod < 0) lsPeriod = n - lsPrev;
         lsPrev = n;
      end
      if (fsA) begin
         if (fsPrev >= 0 && fsPeriod < 0) fsPeriod = n - fsPrev;
         fsPrev = n;
      end
   endtask

   task automatic applyStimulus(input int stallPct);
      en = ($urandom_range(99) >= stallPct);
      if (en) begin
         dataA = srcData(CFG_A, n);
         dataB = srcData(CFG_B, n);
      end else begin
         dataA = 24'($urandom);
         dataB = 24'($urandom);
      end
   endtask

   // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
   task automatic stepCycle(input int stallPct);
      applyStimulus(stallPct);
      @(posedge pclk);
      if (en) n++;
      @(negedge pclk);
      checkAll();
      if (measureOn) measureA();
   endtask

   initial begin
      bit found;
      int m;
      checkCount = 0;
      failCount  = 0;
      salt       = int'($urandom);
      n          = 0;
      measureOn  = 1'b0;
      vCnt = 0; hsLow = 0; hsFirst = -1; blankValid = 0;
      lsPrev = -1; lsPeriod = -1; fsPrev = -1; fsPeriod = -1;
      reset = 1'b1;
      en    = 1'b0;
      dataA = '0;
      dataB = '0;

      repeat (3) @(negedge pclk);
      checkAll();
      reset = 1'b0;

      measureOn = 1'b1;
      for (int i = 0; i < 10410; i++) stepCycle(0);
      measureOn = 1'b0;
      checkOutput("lineValidCount",   64'(vCnt),       64'd640);
      checkOutput("lineHsyncLow",     64'(hsLow),      64'd96);
      checkOutput("hsyncFirstX",      64'(hsFirst),    64'd656);
      checkOutput("lineStartPeriod",  64'(lsPeriod),   64'd800);
      checkOutput("frameStartPeriod", 64'(fsPeriod),   64'd10400);
      checkOutput("blankLinesValid",  64'(blankValid), 64'd0);

      for (int i = 0; i < 4000; i++) stepCycle(25);

      found = 1'b0;
      for (int i = 0; i < 12000 && !found; i++) begin
         stepCycle(0);
         m = n - (CFG_A.pipe + 1);
         if (m >= 0 && (m % 800) == 100 && ((m / 800) % 13) == 3) found = 1'b1;
      end
      checkOutput("midResetReached", 64'(found), 64'd1);
      #2 reset = 1'b1;
      #1 n = 0;
      checkAll();
      @(negedge pclk);
      checkAll();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) stepCycle(0);
      checkOutput("postResetValid",      64'(validA), 64'd1);
      checkOutput("postResetFrameStart", 64'(fsA),    64'd1);
      checkOutput("postResetRgb",        64'({rA, gA, bA}), 64'(pixVal(0, 0)));
      for (int i = 0; i < 900; i++) stepCycle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

endmodule
